rx_block_sync: RTL and testbench

- Receive-side neighbour of the transmit frame generator. Consumes the 64-bit data word and 2-bit sync header recovered by the transceiver gearbox.
- Establishes 64b/66b-style block lock by checking sync headers, and requests bitslip from the gearbox while hunting.
- Forwards locked words downstream to the frame checker with a one-cycle register stage.
- Counts header errors seen while locked.

---
 rtl/rx_block_sync_pkg.sv | 29 ++
 rtl/rx_block_sync_sat_counter.sv | 20 ++
 rtl/rx_block_sync.sv | 137 +++++++++++++
 tb/tb_rx_block_sync.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_block_sync_pkg.sv
// Shared definitions for the block-sync receiver and the frame generator.
package rx_block_sync_pkg;

    // Block-sync FSM encoding
    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } sync_state_t;

    // 64b/66b sync header values
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned HDR_W  = 2;

    // One recovered 66-bit block
    typedef struct packed {
        logic [HDR_W-1:0]  header;
        logic [WORD_W-1:0] data;
    } rx_word_t;

    // A header is usable only if it shows a transition
    function automatic logic header_valid(input logic [HDR_W-1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_sync_sat_counter.sv
// Saturating up-counter; holds at all-ones until reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_block_sync.sv
// 64b/66b block lock: hunts for sync headers, requests bitslip, forwards locked words.
module rx_block_sync
    import rx_block_sync_pkg::*;
#(
    parameter int unsigned LOCK_COUNT    = 64,
    parameter int unsigned ERR_WINDOW    = 64,
    parameter int unsigned ERR_LIMIT     = 16,
    parameter int unsigned SLIP_WAIT     = 32,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET_N,
    input  logic [WORD_W-1:0]        RX_DATA_IN,
    input  logic [HDR_W-1:0]         RX_HEADER_IN,
    input  logic                     RX_DATA_VALID_IN,
    output logic                     RX_SLIP_OUT,
    output logic                     BLOCK_LOCK_OUT,
    output logic [WORD_W-1:0]        RX_DATA_OUT,
    output logic [HDR_W-1:0]         RX_HEADER_OUT,
    output logic                     RX_VALID_OUT,
    output logic [ERR_CNT_WIDTH-1:0] HEADER_ERR_COUNT_OUT
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W  = $clog2(ERR_WINDOW + 1);
    localparam int unsigned BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    sync_state_t       state;
    logic [GOOD_W-1:0] good_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    rx_word_t          word_q;

    logic hdr_ok;
    logic err_inc;

    assign hdr_ok  = header_valid(RX_HEADER_IN);
    assign err_inc = RX_DATA_VALID_IN && (state == ST_LOCKED) && !hdr_ok;

    // Lock FSM with its run, window, error and slip-wait counters
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state          <= ST_HUNT;
            good_cnt       <= '0;
            win_cnt        <= '0;
            bad_cnt        <= '0;
            wait_cnt       <= '0;
            RX_SLIP_OUT    <= 1'b0;
            BLOCK_LOCK_OUT <= 1'b0;
        end else begin
            RX_SLIP_OUT <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (RX_DATA_VALID_IN) begin
                        if (!hdr_ok) begin
                            RX_SLIP_OUT <= 1'b1;
                            good_cnt    <= '0;
                            wait_cnt    <= '0;
                            state       <= ST_SLIP_WAIT;
                        end else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                            good_cnt       <= '0;
                            win_cnt        <= '0;
                            bad_cnt        <= '0;
                            BLOCK_LOCK_OUT <= 1'b1;
                            state          <= ST_LOCKED;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    // Gearbox needs time to settle after a slip; input is ignored
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_cnt <= '0;
                        good_cnt <= '0;
                        state    <= ST_HUNT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (RX_DATA_VALID_IN) begin
                        // Lock loss takes priority over window rollover
                        if (!hdr_ok && (bad_cnt == BAD_W'(ERR_LIMIT - 1))) begin
                            RX_SLIP_OUT    <= 1'b1;
                            BLOCK_LOCK_OUT <= 1'b0;
                            win_cnt        <= '0;
                            bad_cnt        <= '0;
                            wait_cnt       <= '0;
                            state          <= ST_SLIP_WAIT;
                        end else if (win_cnt == WIN_W'(ERR_WINDOW - 1)) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            if (!hdr_ok) begin
                                bad_cnt <= bad_cnt + BAD_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state          <= ST_HUNT;
                    BLOCK_LOCK_OUT <= 1'b0;
                end
            endcase
        end
    end

    // Output register: capture every strobed word, flag only those seen while locked
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            word_q       <= '0;
            RX_VALID_OUT <= 1'b0;
        end else begin
            if (RX_DATA_VALID_IN) begin
                word_q <= '{header: RX_HEADER_IN, data: RX_DATA_IN};
            end
            RX_VALID_OUT <= RX_DATA_VALID_IN && (state == ST_LOCKED);
        end
    end

    assign RX_DATA_OUT   = word_q.data;
    assign RX_HEADER_OUT = word_q.header;

    sat_counter #(
        .WIDTH(ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk  (USER_CLK),
        .rst_n(SYSTEM_RESET_N),
        .inc  (err_inc),
        .count(HEADER_ERR_COUNT_OUT)
    );

endmodule

// File: tb/tb_rx_block_sync.sv
// Randomised scoreboard bench for rx_block_sync (16-bit and 4-bit error counter builds).
module tb_rx_block_sync;
    import rx_block_sync_pkg::*;

    localparam int LOCK_N = 64;
    localparam int WIN_N  = 64;
    localparam int LIM_N  = 16;
    localparam int WAIT_N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] din = '0;
    logic [1:0]  hin = '0;
    logic        vin = 1'b0;

    logic        slip_a, lock_a, vout_a, slip_b, lock_b, vout_b;
    logic [63:0] dout_a, dout_b;
    logic [1:0]  hout_a, hout_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    rx_block_sync #(.ERR_CNT_WIDTH(16)) dut_a (
        .USER_CLK(clk), .SYSTEM_RESET_N(rst_n), .RX_DATA_IN(din), .RX_HEADER_IN(hin),
        .RX_DATA_VALID_IN(vin), .RX_SLIP_OUT(slip_a), .BLOCK_LOCK_OUT(lock_a),
        .RX_DATA_OUT(dout_a), .RX_HEADER_OUT(hout_a), .RX_VALID_OUT(vout_a),
        .HEADER_ERR_COUNT_OUT(cnt_a));

    rx_block_sync #(.ERR_CNT_WIDTH(4)) dut_b (
        .USER_CLK(clk), .SYSTEM_RESET_N(rst_n), .RX_DATA_IN(din), .RX_HEADER_IN(hin),
        .RX_DATA_VALID_IN(vin), .RX_SLIP_OUT(slip_b), .BLOCK_LOCK_OUT(lock_b),
        .RX_DATA_OUT(dout_b), .RX_HEADER_OUT(hout_b), .RX_VALID_OUT(vout_b),
        .HEADER_ERR_COUNT_OUT(cnt_b));

    typedef struct {
        bit          slip;
        bit          lock;
        bit          vout;
        logic [63:0] dout;
        logic [1:0]  hout;
        int          total;
    } stat_t;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  h;
    } word_t;

    stat_t stat_q[$];
    word_t word_q[$];

    int nchecks = 0;
    int nerrs   = 0;

    // Reference model: lock status, run of good headers, window tallies, wait cycles left
    bit          m_locked;
    int          m_run, m_wait, m_win, m_errs, m_total;
    logic [63:0] m_dout;
    logic [1:0]  m_hout;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit good_hdr(input logic [1:0] h);
        return h == 2'b01 || h == 2'b10;
    endfunction

    function automatic logic [1:0] rnd_good();
        return ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
    endfunction

    function automatic logic [1:0] rnd_bad();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic [63:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_wait = 0; m_win = 0; m_errs = 0; m_total = 0;
        m_dout = '0; m_hout = '0;
    endtask

    // Drive one cycle of input and push what the DUT must show after the next edge
    task automatic step(input bit v, input logic [1:0] h, input logic [63:0] d);
        stat_t s;
        bit fwd, slip;
        @(negedge clk);
        vin = v; hin = h; din = d;
        fwd  = v && m_locked;
        slip = 0;
        if (v) begin m_dout = d; m_hout = h; end
        if (m_wait > 0) begin
            m_wait--;
        end else if (!m_locked) begin
            if (v) begin
                if (good_hdr(h)) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_locked = 1; m_run = 0; m_win = 0; m_errs = 0;
                    end
                end else begin
                    m_run = 0; slip = 1; m_wait = WAIT_N;
                end
            end
        end else if (v) begin
            m_win++;
            if (!good_hdr(h)) begin m_total++; m_errs++; end
            if (!good_hdr(h) && m_errs == LIM_N) begin
                slip = 1; m_locked = 0; m_win = 0; m_errs = 0; m_wait = WAIT_N;
            end else if (m_win == WIN_N) begin
                m_win = 0; m_errs = 0;
            end
        end
        s.slip = slip; s.lock = m_locked; s.vout = fwd;
        s.dout = m_dout; s.hout = m_hout; s.total = m_total;
        stat_q.push_back(s);
        if (fwd) word_q.push_back('{d: d, h: h});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_slip"}, {63'd0, slip_a | slip_b}, 64'd0);
        chk({tag, "_lock"}, {63'd0, lock_a | lock_b}, 64'd0);
        chk({tag, "_vout"}, {63'd0, vout_a | vout_b}, 64'd0);
        chk({tag, "_data"}, dout_a | dout_b, 64'd0);
        chk({tag, "_hdr"}, {62'd0, hout_a | hout_b}, 64'd0);
        chk({tag, "_cnt"}, {48'd0, cnt_a | {12'd0, cnt_b}}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vin = 1'b0; hin = '0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    // One error window of 64 strobed words with nbad invalid headers, random gaps
    task automatic window(input int nbad);
        bit flags[64];
        int n = 0;
        for (int i = 0; i < 64; i++) flags[i] = 0;
        while (n < nbad) begin
            int p = $urandom_range(0, 63);
            if (!flags[p]) begin flags[p] = 1; n++; end
        end
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 7) == 0) step(0, rnd_bad(), rnd_data());
            step(1, flags[i] ? rnd_bad() : rnd_good(), rnd_data());
        end
    endtask

    task automatic align_window();
        for (int i = 0; i < 70 && m_locked && m_win != 0; i++) step(1, rnd_good(), rnd_data());
    endtask

    // Monitor: status every cycle, data words whenever RX_VALID_OUT is presented
    initial begin
        stat_t s;
        word_t w;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("slip_a", {63'd0, slip_a}, {63'd0, s.slip});
                chk("lock_a", {63'd0, lock_a}, {63'd0, s.lock});
                chk("vout_a", {63'd0, vout_a}, {63'd0, s.vout});
                chk("data_a", dout_a, s.dout);
                chk("hdr_a", {62'd0, hout_a}, {62'd0, s.hout});
                chk("cnt_a", {48'd0, cnt_a}, 64'((s.total > 65535) ? 65535 : s.total));
                chk("slip_b", {63'd0, slip_b}, {63'd0, s.slip});
                chk("lock_b", {63'd0, lock_b}, {63'd0, s.lock});
                chk("data_b", dout_b, s.dout);
                chk("cnt_b", {60'd0, cnt_b}, 64'((s.total > 15) ? 15 : s.total));
            end
            if (vout_a) begin
                if (word_q.size() == 0) begin
                    chk("unexpected_word", 64'd1, 64'd0);
                end else begin
                    w = word_q.pop_front();
                    chk("word_data", dout_a, w.d);
                    chk("word_hdr", {62'd0, hout_a}, {62'd0, w.h});
                end
            end
        end
    end

    initial begin
        #1ms;
        nerrs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Lock acquisition with data = index
        for (int i = 0; i < 64; i++) step(1, SYNC_DATA, 64'(i));
        step(1, SYNC_DATA, 64'd64);
        for (int i = 0; i < 6; i++) step(1, rnd_good(), rnd_data());

        // Hunt failure, ignored slip-wait inputs, then relock
        do_reset();
        for (int i = 0; i < 10; i++) step(1, rnd_good(), rnd_data());
        step(1, 2'b00, rnd_data());
        for (int i = 0; i < 32; i++) step($urandom_range(0, 3) != 0, (i % 2 == 0) ? 2'b11 : rnd_bad(), rnd_data());
        for (int i = 0; i < 64; i++) step(1, rnd_good(), rnd_data());
        for (int i = 0; i < 4; i++) step(1, rnd_good(), rnd_data());

        // Window rollover with 15 errors twice, then lock loss on the 16th
        align_window();
        window(15);
        window(15);
        window(16);
        for (int i = 0; i < 110; i++) step(1, rnd_good(), rnd_data());

        // Valid gaps during acquisition, then saturate the narrow counter
        do_reset();
        for (int i = 0; i < 140; i++) step(i % 2 == 0, rnd_good(), rnd_data());
        align_window();
        window(15);
        window(15);
        window(15);

        // Asynchronous reset between edges while locked
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        vin = 1'b0; hin = '0; din = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) step(1, rnd_good(), rnd_data());

        // Random traffic with sparse errors and occasional error bursts
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int j = 0; j < 20; j++) step(1, rnd_bad(), rnd_data());
            end
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 24) == 0) ? rnd_bad() : rnd_good(), rnd_data());
        end

        step(0, 2'b00, 64'd0);
        step(0, 2'b00, 64'd0);
        @(posedge clk);
        #2;
        chk("stat_q_drained", 64'(stat_q.size()), 64'd0);
        chk("word_q_drained", 64'(word_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
